// File: rtl/wb_drain_ctrl.sv
// Eviction-buffer drain controller: arbitrates the pmem port between write-backs and fill reads.
// Define WB_DRAIN_STATS_EN to build the drain/fill statistics counters.
module wb_drain_ctrl #(
    parameter int unsigned MAX_READ_STREAK = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         buf_waiting,
    input  logic         buf_full,
    input  logic [255:0] buf_line,
    input  logic [10:0]  buf_tag,
    output logic         buf_inc,
    input  logic         rd_req,
    input  logic [15:0]  rd_addr,
    output logic         rd_resp,
    output logic [255:0] rd_data,
    output logic         wb_busy,
    output logic [10:0]  wb_tag,
    output logic         pmem_read,
    output logic         pmem_write,
    output logic [15:0]  pmem_address,
    output logic [255:0] pmem_wdata,
    input  logic [255:0] pmem_rdata,
    input  logic         pmem_resp,
    output logic [15:0]  drain_count,
    output logic [15:0]  fill_count
);

    localparam int unsigned StreakW = $clog2(MAX_READ_STREAK + 1);
    localparam logic [StreakW-1:0] StreakMax = StreakW'(MAX_READ_STREAK);

    typedef enum logic [1:0] {StIdle, StRd, StWr, StPop} state_e;

    state_e               state_q, state_d;
    logic [StreakW-1:0]   streak_q, streak_d;
    logic [255:0]         wb_line_q;
    logic [10:0]          wb_tag_q;
    logic [10:0]          rd_tag_q;
    logic                 load_wb;
    logic                 load_rd;

    // Line offset bits of the fill address are never used.
    logic unused_rd_offset;
    assign unused_rd_offset = ^rd_addr[4:0];

    always_comb begin
        state_d      = state_q;
        streak_d     = streak_q;
        load_wb      = 1'b0;
        load_rd      = 1'b0;
        buf_inc      = 1'b0;
        rd_resp      = 1'b0;
        rd_data      = '0;
        wb_busy      = 1'b0;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = '0;
        pmem_wdata   = '0;
        case (state_q)
            StIdle: begin
                if (!buf_waiting) begin
                    streak_d = '0;
                end
                if (buf_waiting && (buf_full || streak_q == StreakMax || !rd_req)) begin
                    state_d  = StWr;
                    load_wb  = 1'b1;
                    streak_d = '0;
                end else if (rd_req) begin
                    state_d = StRd;
                    load_rd = 1'b1;
                    // Only reads that bypass a waiting drain count toward starvation.
                    if (buf_waiting && streak_q != StreakMax) begin
                        streak_d = streak_q + StreakW'(1);
                    end
                end
            end
            StRd: begin
                pmem_read    = 1'b1;
                pmem_address = {rd_tag_q, 5'b0};
                rd_resp      = pmem_resp;
                rd_data      = pmem_rdata;
                if (pmem_resp) begin
                    state_d = StIdle;
                end
            end
            StWr: begin
                pmem_write   = 1'b1;
                pmem_address = {wb_tag_q, 5'b0};
                pmem_wdata   = wb_line_q;
                wb_busy      = 1'b1;
                if (pmem_resp) begin
                    state_d = StPop;
                end
            end
            StPop: begin
                buf_inc = 1'b1;
                wb_busy = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            streak_q  <= '0;
            wb_line_q <= '0;
            wb_tag_q  <= '0;
            rd_tag_q  <= '0;
        end else begin
            state_q  <= state_d;
            streak_q <= streak_d;
            if (load_wb) begin
                wb_line_q <= buf_line;
                wb_tag_q  <= buf_tag;
            end
            if (load_rd) begin
                rd_tag_q <= rd_addr[15:5];
            end
        end
    end

    assign wb_tag = wb_tag_q;

`ifdef WB_DRAIN_STATS_EN
    logic [15:0] drain_cnt_q;
    logic [15:0] fill_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            drain_cnt_q <= '0;
            fill_cnt_q  <= '0;
        end else begin
            if (state_q == StPop) begin
                drain_cnt_q <= drain_cnt_q + 16'd1;
            end
            if (rd_resp) begin
                fill_cnt_q <= fill_cnt_q + 16'd1;
            end
        end
    end

    assign drain_count = drain_cnt_q;
    assign fill_count  = fill_cnt_q;
`else
    assign drain_count = 16'h0000;
    assign fill_count  = 16'h0000;
`endif

endmodule

// File: tb/tb_wb_drain_ctrl.sv
// Scoreboard bench for wb_drain_ctrl: expected pmem transactions are queued at stimulus time
// and popped as the memory model completes them.
module tb_wb_drain_ctrl;

    logic         clk;
    logic         rst_n;
    logic         buf_waiting;
    logic         buf_full;
    logic [255:0] buf_line;
    logic [10:0]  buf_tag;
    logic         buf_inc;
    logic         rd_req;
    logic [15:0]  rd_addr;
    logic         rd_resp;
    logic [255:0] rd_data;
    logic         wb_busy;
    logic [10:0]  wb_tag;
    logic         pmem_read;
    logic         pmem_write;
    logic [15:0]  pmem_address;
    logic [255:0] pmem_wdata;
    logic [255:0] pmem_rdata;
    logic         pmem_resp;
    logic [15:0]  drain_count;
    logic [15:0]  fill_count;

`ifdef WB_DRAIN_STATS_EN
    localparam bit StatsEn = 1'b1;
`else
    localparam bit StatsEn = 1'b0;
`endif

    typedef struct {
        logic         wr;
        logic [15:0]  addr;
        logic [255:0] data;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   mem_lat = 3;
    int   lat_cnt = 0;
    logic prev_wr_resp = 1'b0;

    wb_drain_ctrl #(.MAX_READ_STREAK(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .buf_waiting  (buf_waiting),
        .buf_full     (buf_full),
        .buf_line     (buf_line),
        .buf_tag      (buf_tag),
        .buf_inc      (buf_inc),
        .rd_req       (rd_req),
        .rd_addr      (rd_addr),
        .rd_resp      (rd_resp),
        .rd_data      (rd_data),
        .wb_busy      (wb_busy),
        .wb_tag       (wb_tag),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_address (pmem_address),
        .pmem_wdata   (pmem_wdata),
        .pmem_rdata   (pmem_rdata),
        .pmem_resp    (pmem_resp),
        .drain_count  (drain_count),
        .fill_count   (fill_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [255:0] mem_data(input logic [15:0] a);
        return {16{a ^ 16'hC3A5}};
    endfunction

    task automatic check_eq(input string tag, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic push_exp(input logic wr, input logic [15:0] addr, input logic [255:0] data);
        exp_t e;
        e.wr   = wr;
        e.addr = addr;
        e.data = data;
        sb.push_back(e);
    endtask

    task automatic wait_inc(input int budget, output logic got);
        got = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            @(negedge clk);
            if (buf_inc) got = 1'b1;
        end
    endtask

    task automatic wait_rresp(input int budget, output logic got);
        got = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            @(negedge clk);
            if (rd_resp) got = 1'b1;
        end
    endtask

    // Memory model: completes a command mem_lat cycles after it appears.
    always @(posedge clk) begin
        #1;
        if (pmem_resp) begin
            pmem_resp = 1'b0;
            lat_cnt   = 0;
        end else if (pmem_read || pmem_write) begin
            lat_cnt++;
            if (lat_cnt >= mem_lat) begin
                pmem_resp  = 1'b1;
                pmem_rdata = mem_data(pmem_address);
            end
        end else begin
            lat_cnt = 0;
        end
    end

    // Monitor: scoreboard pops on completions plus per-cycle protocol checks.
    always @(negedge clk) begin
        exp_t e;
        if (pmem_read || pmem_write) check_eq("rw_excl", 256'(pmem_read & pmem_write), 256'(0));
        if (pmem_write) check_eq("wr_busy", 256'(wb_busy), 256'(1));
        if (buf_inc) check_eq("inc_after_resp", 256'(prev_wr_resp), 256'(1));
        if (pmem_resp && (pmem_read || pmem_write)) begin
            check_eq("sb_nonempty", 256'(sb.size() != 0), 256'(1));
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check_eq("sb_kind", 256'(pmem_write), 256'(e.wr));
                check_eq("sb_addr", 256'(pmem_address), 256'(e.addr));
                if (e.wr) begin
                    check_eq("sb_wdata", pmem_wdata, e.data);
                end else begin
                    check_eq("sb_rresp", 256'(rd_resp), 256'(1));
                    check_eq("sb_rdata", rd_data, e.data);
                end
            end
        end
        prev_wr_resp = pmem_resp && pmem_write;
    end

    initial begin
        logic [255:0] la, lb, lc, ld, le, lf;
        logic got;
        logic read_seen;
        int   nfill;
        int   fills_at_inc;
        bit   done;

        la = {8{32'h1111_0001}};
        lb = {8{32'h2222_0002}};
        lc = {8{32'h3333_0003}};
        ld = {8{32'h4444_0004}};
        le = {8{32'h5555_0005}};
        lf = {8{32'h6666_0006}};

        rst_n = 1'b0; buf_waiting = 1'b0; buf_full = 1'b0; buf_line = '0; buf_tag = '0;
        rd_req = 1'b0; rd_addr = '0; pmem_rdata = '0; pmem_resp = 1'b0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check_eq("rst_read", 256'(pmem_read), 256'(0));
        check_eq("rst_write", 256'(pmem_write), 256'(0));
        check_eq("rst_inc", 256'(buf_inc), 256'(0));
        check_eq("rst_busy", 256'(wb_busy), 256'(0));
        check_eq("rst_tag", 256'(wb_tag), 256'(0));
        check_eq("rst_addr", 256'(pmem_address), 256'(0));
        check_eq("rst_rresp", 256'(rd_resp), 256'(0));
        check_eq("rst_dcnt", 256'(drain_count), 256'(0));
        check_eq("rst_fcnt", 256'(fill_count), 256'(0));
        rst_n = 1'b1;
        @(negedge clk);

        // Single drain
        buf_line = la; buf_tag = 11'h123; buf_waiting = 1'b1;
        push_exp(1'b1, 16'h2460, la);
        @(negedge clk);
        check_eq("drain_start", 256'(pmem_write), 256'(1));
        check_eq("drain_addr", 256'(pmem_address), 256'(16'h2460));
        wait_inc(20, got);
        check_eq("drain_inc", 256'(got), 256'(1));
        buf_waiting = 1'b0;
        @(negedge clk);
        check_eq("drain_idle", 256'(wb_busy), 256'(0));
        check_eq("drain_one_inc", 256'(buf_inc), 256'(0));
        check_eq("drain_cnt1", 256'(drain_count), 256'(StatsEn ? 1 : 0));

        // Read priority over a non-urgent drain
        rd_req = 1'b1; rd_addr = 16'h1234; buf_waiting = 1'b1; buf_tag = 11'h0AB; buf_line = lb;
        push_exp(1'b0, 16'h1220, mem_data(16'h1220));
        push_exp(1'b1, 16'h1560, lb);
        @(negedge clk);
        check_eq("prio_read", 256'(pmem_read), 256'(1));
        check_eq("prio_nowr", 256'(pmem_write), 256'(0));
        check_eq("prio_addr", 256'(pmem_address), 256'(16'h1220));
        wait_rresp(20, got);
        check_eq("prio_rresp", 256'(got), 256'(1));
        rd_req = 1'b0;
        @(negedge clk);
        check_eq("prio_gap", 256'(pmem_write), 256'(0));
        @(negedge clk);
        check_eq("prio_wr", 256'(pmem_write), 256'(1));
        wait_inc(20, got);
        check_eq("prio_inc", 256'(got), 256'(1));
        buf_waiting = 1'b0;
        @(negedge clk);

        // Starvation limit: four fills, one forced drain, fills resume
        rd_req = 1'b1; rd_addr = 16'h4000; buf_waiting = 1'b1; buf_tag = 11'h3FF; buf_line = lc;
        for (int i = 0; i < 4; i++) push_exp(1'b0, 16'h4000, mem_data(16'h4000));
        push_exp(1'b1, 16'h7FE0, lc);
        for (int i = 0; i < 2; i++) push_exp(1'b0, 16'h4000, mem_data(16'h4000));
        nfill = 0; fills_at_inc = -1; done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (buf_inc) begin
                fills_at_inc = nfill;
                buf_waiting  = 1'b0;
            end
            if (rd_resp) begin
                nfill++;
                if (nfill == 6) begin
                    rd_req = 1'b0;
                    done   = 1'b1;
                end
            end
        end
        check_eq("starve_before_drain", 256'(fills_at_inc), 256'(4));
        check_eq("starve_fills", 256'(nfill), 256'(6));
        @(negedge clk);

        // Full buffer overrides a pending read
        buf_full = 1'b1; buf_waiting = 1'b1; rd_req = 1'b1; rd_addr = 16'h085F;
        buf_tag = 11'h555; buf_line = ld;
        push_exp(1'b1, 16'hAAA0, ld);
        push_exp(1'b0, 16'h0840, mem_data(16'h0840));
        @(negedge clk);
        check_eq("full_wr", 256'(pmem_write), 256'(1));
        read_seen = 1'b0; got = 1'b0;
        for (int i = 0; i < 30 && !got; i++) begin
            @(negedge clk);
            if (pmem_read) read_seen = 1'b1;
            if (buf_inc) got = 1'b1;
        end
        check_eq("full_inc", 256'(got), 256'(1));
        check_eq("full_no_read", 256'(read_seen), 256'(0));
        buf_waiting = 1'b0; buf_full = 1'b0;
        wait_rresp(20, got);
        check_eq("full_rresp", 256'(got), 256'(1));
        rd_req = 1'b0;
        @(negedge clk);

        // Data stability while the write is in flight
        mem_lat = 5;
        buf_waiting = 1'b1; buf_tag = 11'h0F0; buf_line = le;
        push_exp(1'b1, 16'h1E00, le);
        @(negedge clk);
        buf_line = ~le; buf_tag = 11'h7FF;
        got = 1'b0;
        for (int i = 0; i < 30 && !got; i++) begin
            @(negedge clk);
            if (pmem_write) begin
                check_eq("stab_addr", 256'(pmem_address), 256'(16'h1E00));
                check_eq("stab_wdata", pmem_wdata, le);
                check_eq("stab_tag", 256'(wb_tag), 256'(11'h0F0));
            end
            if (buf_inc) begin
                got = 1'b1;
                check_eq("stab_pop_busy", 256'(wb_busy), 256'(1));
            end
        end
        check_eq("stab_inc", 256'(got), 256'(1));
        buf_waiting = 1'b0;
        @(negedge clk);
        check_eq("stats_drains", 256'(drain_count), 256'(StatsEn ? 5 : 0));
        check_eq("stats_fills", 256'(fill_count), 256'(StatsEn ? 8 : 0));

        // Reset in the middle of a write; the line is drained again afterwards
        mem_lat = 4;
        buf_waiting = 1'b1; buf_tag = 11'h2AA; buf_line = lf;
        push_exp(1'b1, 16'h5540, lf);
        @(negedge clk);
        check_eq("rwr_start", 256'(pmem_write), 256'(1));
        rst_n = 1'b0;
        @(negedge clk);
        check_eq("rwr_nowr", 256'(pmem_write), 256'(0));
        check_eq("rwr_noinc", 256'(buf_inc), 256'(0));
        check_eq("rwr_busy", 256'(wb_busy), 256'(0));
        check_eq("rwr_dcnt", 256'(drain_count), 256'(0));
        check_eq("rwr_fcnt", 256'(fill_count), 256'(0));
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("redrain_start", 256'(pmem_write), 256'(1));
        check_eq("redrain_addr", 256'(pmem_address), 256'(16'h5540));
        wait_inc(20, got);
        check_eq("redrain_inc", 256'(got), 256'(1));
        buf_waiting = 1'b0;
        @(negedge clk);
        check_eq("redrain_cnt", 256'(drain_count), 256'(StatsEn ? 1 : 0));
        check_eq("sb_drained", 256'(sb.size()), 256'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
